// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RV32I core, with bounded memory waits.
// Optional feature macro: ILLEGAL_TRAP_EN (unknown opcodes trap instead of retiring as NOPs).

module cpu_seq_ctrl_chk (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_retired,
    input  logic       bus_err,
    input  logic       mem_we,
    input  logic       mem_req,
    input  logic       pc_write
);
    // Cycle-level safety properties of the sequencer outputs
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(instr_retired && bus_err));
            assert (!mem_we || mem_req);
            assert (!(bus_err && pc_write));
        end
    end
endmodule

module cpu_seq_ctrl #(
    parameter int WIDTH       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] instruction,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             alu_src_b,
    output logic [2:0]       imm_sel,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic             instr_retired,
    output logic             bus_err,
    output logic             illegal_instr
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_IMM = 2'd2;
    localparam logic [1:0] WB_PC4 = 2'd3;

    localparam logic [7:0] TO_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_t      state_r;
    state_t      next_state_s;
    logic [6:0]  opcode_r;
    logic [7:0]  wait_cnt_r;
    logic        waiting_s;
    logic        abort_s;
    logic        known_s;
    logic        unused_s;

    function automatic logic op_known(input logic [6:0] op);
        logic k;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI: k = 1'b1;
            default:                                                 k = 1'b0;
        endcase
        return k;
    endfunction

    function automatic logic [2:0] imm_fmt(input logic [6:0] op);
        logic [2:0] f;
        case (op)
            OP_I, OP_LOAD: f = IMM_I;
            OP_STORE:      f = IMM_S;
            OP_BRANCH:     f = IMM_B;
            OP_LUI:        f = IMM_U;
            OP_JAL:        f = IMM_J;
            default:       f = IMM_I;
        endcase
        return f;
    endfunction

    assign unused_s  = ^instruction[WIDTH-1:7];
    assign known_s   = op_known(opcode_r);
    assign waiting_s = (state_r == S_FETCH) || (state_r == S_MEM);
    // mem_ready on the limit cycle wins over the abort
    assign abort_s   = waiting_s && !mem_ready && (wait_cnt_r == TO_LIMIT);
    assign state     = state_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Opcode capture on a completed fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_r <= 7'd0;
        end else if ((state_r == S_FETCH) && mem_ready) begin
            opcode_r <= instruction[6:0];
        end else begin
            opcode_r <= opcode_r;
        end
    end

    // Memory wait counter; any exit from the wait (ready, abort, state change) clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= 8'd0;
        end else if (waiting_s && !mem_ready && !abort_s) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= 8'd0;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_r;
    logic set_illegal_s;

    // Sticky illegal-opcode flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= illegal_r | set_illegal_s;
        end
    end

    assign illegal_instr = illegal_r;
`else
    assign illegal_instr = 1'b0;
`endif

    // Next-state and control decode
    always_comb begin
        next_state_s  = state_r;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        alu_src_b     = 1'b0;
        imm_sel       = imm_fmt(opcode_r);
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        instr_retired = 1'b0;
        bus_err       = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        set_illegal_s = 1'b0;
`endif
        case (state_r)
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                if (mem_ready) begin
                    next_state_s = S_DECODE;
                end else if (abort_s) begin
                    bus_err      = 1'b1;
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (known_s) begin
                    next_state_s = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    set_illegal_s = 1'b1;
                    next_state_s  = S_TRAP;
`else
                    pc_write      = 1'b1;
                    instr_retired = 1'b1;
                    next_state_s  = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                case (opcode_r)
                    OP_LOAD, OP_STORE: begin
                        alu_src_b    = 1'b1;
                        next_state_s = S_MEM;
                    end
                    OP_I, OP_LUI: begin
                        alu_src_b    = 1'b1;
                        next_state_s = S_WB;
                    end
                    OP_R: begin
                        next_state_s = S_WB;
                    end
                    OP_BRANCH: begin
                        pc_write      = 1'b1;
                        pc_src        = branch_taken;
                        instr_retired = 1'b1;
                        next_state_s  = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_write      = 1'b1;
                        pc_src        = 1'b1;
                        reg_write     = 1'b1;
                        wb_sel        = WB_PC4;
                        instr_retired = 1'b1;
                        next_state_s  = S_FETCH;
                    end
                    default: begin
                        next_state_s = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode_r == OP_STORE);
                if (mem_ready) begin
                    if (opcode_r == OP_STORE) begin
                        pc_write      = 1'b1;
                        instr_retired = 1'b1;
                        next_state_s  = S_FETCH;
                    end else begin
                        next_state_s  = S_WB;
                    end
                end else if (abort_s) begin
                    bus_err      = 1'b1;
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WB: begin
                reg_write     = 1'b1;
                pc_write      = 1'b1;
                instr_retired = 1'b1;
                next_state_s  = S_FETCH;
                case (opcode_r)
                    OP_LOAD: wb_sel = WB_MEM;
                    OP_LUI:  wb_sel = WB_IMM;
                    default: wb_sel = WB_ALU;
                endcase
            end
            S_TRAP: begin
                imm_sel = IMM_I;
`ifdef ILLEGAL_TRAP_EN
                next_state_s = S_TRAP;
`else
                next_state_s = S_FETCH;
`endif
            end
            default: begin
                next_state_s = S_FETCH;
            end
        endcase
    end

    cpu_seq_ctrl_chk u_chk (
        .clk           (clk),
        .rst           (rst),
        .instr_retired (instr_retired),
        .bus_err       (bus_err),
        .mem_we        (mem_we),
        .mem_req       (mem_req),
        .pc_write      (pc_write)
    );

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: a driver issues directed instructions and queues expected
// retire/abort records; a monitor builds per-instruction observations and compares on each event.

module tb_cpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = 32'd0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_sel, alu_src_b;
    logic [2:0]  imm_sel;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic        instr_retired, bus_err, illegal_instr;

    cpu_seq_ctrl #(.WIDTH(32), .MEM_TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .instruction   (instruction),
        .mem_ready     (mem_ready),
        .branch_taken  (branch_taken),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr_sel  (mem_addr_sel),
        .alu_src_b     (alu_src_b),
        .imm_sel       (imm_sel),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .state         (state),
        .instr_retired (instr_retired),
        .bus_err       (bus_err),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    err;
        int    lat;
        int    pcw;
        int    src;
        int    regw;
        int    wb;
        int    imm;
        int    st;
        int    alub;
        int    we;
        int    addr;
        int    irw;
        int    trace;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   events_seen = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input string nm, input int err, input int lat, input int pcw,
                                input int src, input int regw, input int wb, input int imm,
                                input int st, input int alub, input int we, input int addr,
                                input int irw, input int trace);
        exp_t e;
        e.name = nm; e.err = err; e.lat = lat; e.pcw = pcw; e.src = src; e.regw = regw;
        e.wb = wb; e.imm = imm; e.st = st; e.alub = alub; e.we = we; e.addr = addr;
        e.irw = irw; e.trace = trace;
        return e;
    endfunction

    // Monitor: accumulates one instruction's observations, compares on retire or bus error
    initial begin
        int   lat, trace, prev, addr, irw, alub, we;
        exp_t e;
        lat = 0; trace = 0; prev = 0; addr = 0; irw = 0; alub = 0; we = 0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                lat = 0; trace = 0; addr = 0; irw = 0; alub = 0; we = 0;
            end else begin
                if (lat == 0) trace = int'(state);
                else if (int'(state) != prev) trace = (trace << 4) | int'(state);
                prev = int'(state);
                lat++;
                if (mem_addr_sel) addr++;
                if (ir_write) irw++;
                if (mem_we) we = 1;
                if (state == 3'd2) alub = int'(alu_src_b);
                if (instr_retired || bus_err) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: retired=%0d bus_err=%0d with empty queue",
                                 instr_retired, bus_err);
                    end else begin
                        e = exp_q.pop_front();
                        chk({e.name, ".both"},  int'(instr_retired & bus_err), 0);
                        chk({e.name, ".err"},   int'(bus_err), e.err);
                        chk({e.name, ".lat"},   lat, e.lat);
                        chk({e.name, ".pcw"},   int'(pc_write), e.pcw);
                        chk({e.name, ".src"},   int'(pc_src), e.src);
                        chk({e.name, ".regw"},  int'(reg_write), e.regw);
                        chk({e.name, ".wb"},    int'(wb_sel), e.wb);
                        chk({e.name, ".imm"},   int'(imm_sel), e.imm);
                        chk({e.name, ".state"}, int'(state), e.st);
                        chk({e.name, ".alub"},  alub, e.alub);
                        chk({e.name, ".we"},    we, e.we);
                        chk({e.name, ".addr"},  addr, e.addr);
                        chk({e.name, ".irw"},   irw, e.irw);
                        chk({e.name, ".trace"}, trace, e.trace);
                    end
                    events_seen++;
                    lat = 0; trace = 0; addr = 0; irw = 0; alub = 0; we = 0;
                end
            end
        end
    end

    // Driver: called at posedge+1; responds to FETCH/MEM with the requested wait counts
    task automatic run(input logic [31:0] ins, input int fw, input int mw, input logic bt);
        int fc, mc, target;
        bit done;
        fc = 0; mc = 0; done = 1'b0;
        target = events_seen + 1;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            instruction  = ins;
            branch_taken = bt;
            if (state == 3'd0) begin
                if (fc < fw) begin mem_ready = 1'b0; fc++; end
                else mem_ready = 1'b1;
            end else if (state == 3'd3) begin
                if (mc < mw) begin mem_ready = 1'b0; mc++; end
                else mem_ready = 1'b1;
            end else begin
                mem_ready = 1'b0;
            end
            @(negedge clk);
            #1;
            if (events_seen >= target) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: instr %h got no event, expected one within 200 cycles", ins);
        end
    endtask

    initial begin
        int mcnt;
        #12;
        chk("rst_state", int'(state), 0);
        chk("rst_outs", int'({ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_sel, alu_src_b,
                              imm_sel, reg_write, wb_sel, instr_retired, bus_err, illegal_instr}),
            int'(16'h1000));
        @(posedge clk);
        #1;
        rst = 1'b0;

        //                       err lat pcw src rw wb imm st alub we addr irw trace
        exp_q.push_back(mk("addi",   0, 4, 1, 0, 1, 0, 0, 4, 1, 0, 0, 1, 32'h0124));
        run(32'h00500093, 0, 0, 1'b0);
        exp_q.push_back(mk("lw_w3",  0, 8, 1, 0, 1, 1, 0, 4, 1, 0, 4, 1, 32'h01234));
        run(32'h0000A103, 0, 3, 1'b0);
        exp_q.push_back(mk("sw",     0, 4, 1, 0, 0, 0, 1, 3, 1, 1, 1, 1, 32'h0123));
        run(32'h0020A023, 0, 0, 1'b0);
        exp_q.push_back(mk("beq_t",  0, 3, 1, 1, 0, 0, 2, 2, 0, 0, 0, 1, 32'h012));
        run(32'h00208463, 0, 0, 1'b1);
        exp_q.push_back(mk("beq_nt", 0, 3, 1, 0, 0, 0, 2, 2, 0, 0, 0, 1, 32'h012));
        run(32'h00208463, 0, 0, 1'b0);
        exp_q.push_back(mk("jal",    0, 3, 1, 1, 1, 3, 4, 2, 0, 0, 0, 1, 32'h012));
        run(32'h008000EF, 0, 0, 1'b0);
        exp_q.push_back(mk("lui",    0, 4, 1, 0, 1, 2, 3, 4, 1, 0, 0, 1, 32'h0124));
        run(32'h12345137, 0, 0, 1'b1);
        exp_q.push_back(mk("add",    0, 4, 1, 0, 1, 0, 0, 4, 0, 0, 0, 1, 32'h0124));
        run(32'h002081B3, 0, 0, 1'b0);
        // fetch never ready: abort on the 16th wait cycle, opcode still from the ADD
        exp_q.push_back(mk("f_tout", 1, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        run(32'h00500093, 16, 0, 1'b0);
        exp_q.push_back(mk("f_lim",  0, 19, 1, 0, 1, 0, 0, 4, 1, 0, 0, 1, 32'h0124));
        run(32'h00500093, 15, 0, 1'b0);
        exp_q.push_back(mk("m_tout", 1, 19, 0, 0, 0, 0, 0, 3, 1, 0, 16, 1, 32'h0123));
        run(32'h0000A103, 0, 16, 1'b0);
        exp_q.push_back(mk("addi2",  0, 4, 1, 0, 1, 0, 0, 4, 1, 0, 0, 1, 32'h0124));
        run(32'h00500093, 0, 0, 1'b0);
        exp_q.push_back(mk("sw_w",   0, 7, 1, 0, 0, 0, 1, 3, 1, 1, 2, 1, 32'h0123));
        run(32'h0020A023, 2, 1, 1'b0);

`ifdef ILLEGAL_TRAP_EN
        instruction = 32'h0000007F;
        mem_ready   = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("trap_state", int'(state), 5);
        chk("trap_flag", int'(illegal_instr), 1);
        chk("trap_ctrl", int'({mem_req, pc_write, reg_write, instr_retired}), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("trap_hold", int'(state), 5);
        chk("trap_sticky", int'(illegal_instr), 1);
        rst = 1'b1;
        #1;
        chk("trap_rst_flag", int'(illegal_instr), 0);
        chk("trap_rst_state", int'(state), 0);
        rst = 1'b0;
`else
        exp_q.push_back(mk("nop7f",  0, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h01));
        run(32'h0000007F, 0, 0, 1'b0);
        chk("illegal_tied", int'(illegal_instr), 0);
`endif

        // reset during the third MEM wait cycle of a LOAD
        instruction = 32'h0000A103;
        mem_ready   = 1'b1;
        mcnt = 0;
        for (int i = 0; i < 12 && mcnt < 3; i++) begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (state == 3'd3) mcnt++;
        end
        chk("mid_state", int'(state), 3);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_state", int'(state), 0);
        chk("mrst_req", int'(mem_req), 1);
        chk("mrst_regw", int'(reg_write), 0);
        chk("mrst_ill", int'(illegal_instr), 0);
        chk("mrst_outs", int'({pc_write, mem_we, mem_addr_sel, alu_src_b, imm_sel, wb_sel,
                               instr_retired, bus_err}), 0);
        rst = 1'b0;
        exp_q.push_back(mk("post_rst", 0, 4, 1, 0, 1, 0, 0, 4, 1, 0, 0, 1, 32'h0124));
        run(32'h00500093, 0, 0, 1'b0);

        chk("queue_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
